// File: rtl/capacity_request_gen.sv
// rtl/capacity_request_gen.sv - elevator capacity request producer
// Counts boarding/leaving passengers and hands a settled occupancy to the capacity check.
module capacity_request_gen #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 8,
    parameter int SET_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             door_open,
    input  logic             enter,
    input  logic             exit,
    input  logic [WIDTH-1:0] cap_max,
    input  logic             req_ack,
    output logic [WIDTH-1:0] cap_curr,
    output logic [WIDTH-1:0] cap_des,
    output logic             req_valid,
    output logic             overload,
    output logic             door_close_ok
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOARD,
        S_SETTLE,
        S_HOLD,
        S_REQ
    } state_t;

    localparam logic [WIDTH-1:0] CAP_TOP   = '1;
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE);
    localparam logic [SET_W-1:0] SETTLE_END = SET_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cap_curr_q, cap_curr_d;
    logic [WIDTH-1:0] cap_des_q, cap_des_d;
    logic [WIDTH-1:0] cap_counted;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             req_valid_q, req_valid_d;
    logic             overload_q, overload_d;
    logic             door_close_ok_q, door_close_ok_d;
    logic             any_evt;

    assign any_evt = enter | exit;

    // Simultaneous enter and exit cancel out; both directions saturate.
    always_comb begin
        cap_counted = cap_des_q;
        if (enter && !exit && cap_des_q != CAP_TOP) begin
            cap_counted = cap_des_q + 1'b1;
        end else if (exit && !enter && cap_des_q != '0) begin
            cap_counted = cap_des_q - 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        cap_curr_d      = cap_curr_q;
        cap_des_d       = cap_des_q;
        settle_d        = settle_q;
        req_valid_d     = req_valid_q;
        overload_d      = overload_q;
        door_close_ok_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (door_open) begin
                    cap_des_d = cap_curr_q;
                    state_d   = S_BOARD;
                end
            end
            S_BOARD: begin
                cap_des_d = cap_counted;
                if (!door_open) begin
                    settle_d = SETTLE_LD;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cap_des_d = cap_counted;
                if (door_open) begin
                    state_d = S_BOARD;
                end else if (any_evt) begin
                    settle_d = SETTLE_LD;
                end else if (settle_q == SETTLE_END) begin
                    settle_d = '0;
                    if (cap_des_q > cap_max) begin
                        overload_d = 1'b1;
                        state_d    = S_HOLD;
                    end else begin
                        req_valid_d = 1'b1;
                        state_d     = S_REQ;
                    end
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            S_HOLD: begin
                // The value released to REQ is the one just validated, so no count on exit.
                if (cap_des_q <= cap_max) begin
                    overload_d  = 1'b0;
                    req_valid_d = 1'b1;
                    state_d     = S_REQ;
                end else begin
                    cap_des_d = cap_counted;
                end
            end
            S_REQ: begin
                if (req_ack) begin
                    cap_curr_d      = cap_des_q;
                    req_valid_d     = 1'b0;
                    door_close_ok_d = 1'b1;
                    state_d         = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_valid_d = 1'b0;
                overload_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cap_curr_q      <= '0;
            cap_des_q       <= '0;
            settle_q        <= '0;
            req_valid_q     <= 1'b0;
            overload_q      <= 1'b0;
            door_close_ok_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cap_curr_q      <= cap_curr_d;
            cap_des_q       <= cap_des_d;
            settle_q        <= settle_d;
            req_valid_q     <= req_valid_d;
            overload_q      <= overload_d;
            door_close_ok_q <= door_close_ok_d;
        end
    end

    assign cap_curr      = cap_curr_q;
    assign cap_des       = cap_des_q;
    assign req_valid     = req_valid_q;
    assign overload      = overload_q;
    assign door_close_ok = door_close_ok_q;

endmodule

// File: tb/tb_capacity_request_gen.sv
// tb/tb_capacity_request_gen.sv - self-checking bench for capacity_request_gen
module tb_capacity_request_gen;

    localparam int W      = 4;
    localparam int SETTLE = 8;
    localparam int MAXV   = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         door_open = 1'b0;
    logic         enter = 1'b0;
    logic         exit = 1'b0;
    logic [W-1:0] cap_max = 4'd15;
    logic         req_ack = 1'b0;
    logic [W-1:0] cap_curr;
    logic [W-1:0] cap_des;
    logic         req_valid;
    logic         overload;
    logic         door_close_ok;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    capacity_request_gen #(.WIDTH(W), .SETTLE(SETTLE), .SET_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .door_open(door_open), .enter(enter), .exit(exit),
        .cap_max(cap_max), .req_ack(req_ack), .cap_curr(cap_curr), .cap_des(cap_des),
        .req_valid(req_valid), .overload(overload), .door_close_ok(door_close_ok)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 closed, 1 door open, 2 door shut and waiting for quiet,
    // 3 over capacity, 4 request outstanding. quiet = consecutive silent cycles seen.
    int m_ph, m_curr, m_des, m_quiet;
    bit m_valid, m_ovl, m_ok;

    function automatic int bump(input int v, input bit en, input bit ex);
        if (en && !ex) return (v == MAXV) ? v : v + 1;
        if (ex && !en) return (v == 0) ? 0 : v - 1;
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ph = 0; m_curr = 0; m_des = 0; m_quiet = 0;
            m_valid = 0; m_ovl = 0; m_ok = 0;
        end else begin
            m_ok = 0;
            case (m_ph)
                0: if (door_open) begin m_des = m_curr; m_ph = 1; end
                1: begin
                    m_des = bump(m_des, enter, exit);
                    if (!door_open) begin m_ph = 2; m_quiet = 0; end
                end
                2: begin
                    m_des = bump(m_des, enter, exit);
                    if (door_open) m_ph = 1;
                    else if (enter || exit) m_quiet = 0;
                    else if (m_quiet == SETTLE - 1) begin
                        if (m_des > int'(cap_max)) begin m_ph = 3; m_ovl = 1; end
                        else begin m_ph = 4; m_valid = 1; end
                    end else m_quiet++;
                end
                3: begin
                    if (m_des <= int'(cap_max)) begin m_ph = 4; m_ovl = 0; m_valid = 1; end
                    else m_des = bump(m_des, enter, exit);
                end
                default: begin
                    if (req_ack) begin m_curr = m_des; m_valid = 0; m_ok = 1; m_ph = 0; end
                end
            endcase
        end
        #1;
        if (chk_en) begin
            cmp("model cap_curr", cap_curr, m_curr);
            cmp("model cap_des", cap_des, m_des);
            cmp("model req_valid", req_valid, m_valid);
            cmp("model overload", overload, m_ovl);
            cmp("model door_close_ok", door_close_ok, m_ok);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!req_valid && n < limit) begin
            step();
            n++;
        end
        if (!req_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: got req_valid 0 expected 1 within %0d cycles", limit);
        end
    endtask

    task automatic pulses(input bit en, input bit ex, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            enter = en; exit = ex;
            step();
        end
        enter = 0; exit = 0;
    endtask

    task automatic finish_req();
        req_ack = 1;
        step();
        req_ack = 0;
        step();
    endtask

    int n;

    initial begin
        repeat (2) @(posedge clk);
        #2;
        cmp("reset cap_curr", cap_curr, 0);
        cmp("reset cap_des", cap_des, 0);
        cmp("reset req_valid", req_valid, 0);
        cmp("reset overload", overload, 0);
        cmp("reset door_close_ok", door_close_ok, 0);
        rst_n = 1;
        chk_en = 1;

        // 1: three boarders, settle timing, delayed ack
        door_open = 1; step();
        pulses(1, 0, 3);
        door_open = 0; step();
        wait_valid(20, n);
        cmp("t1 settle latency", n, 8);
        cmp("t1 cap_des", cap_des, 3);
        step(); step();
        cmp("t1 valid held", req_valid, 1);
        req_ack = 1; step(); req_ack = 0;
        cmp("t1 cap_curr", cap_curr, 3);
        cmp("t1 door_close_ok", door_close_ok, 1);
        cmp("t1 req_valid drop", req_valid, 0);
        step();
        cmp("t1 door_close_ok end", door_close_ok, 0);

        // 2: overload hold then release
        door_open = 1; step();
        pulses(0, 1, 1);
        door_open = 0; step();
        wait_valid(20, n);
        finish_req();
        cmp("t2 cap_curr start", cap_curr, 2);
        cap_max = 4;
        door_open = 1; step();
        pulses(1, 0, 4);
        door_open = 0; step();
        repeat (8) step();
        cmp("t2 overload", overload, 1);
        cmp("t2 no valid in hold", req_valid, 0);
        pulses(0, 1, 2);
        cmp("t2 cap_des", cap_des, 4);
        step();
        cmp("t2 overload clear", overload, 0);
        cmp("t2 valid after hold", req_valid, 1);
        finish_req();
        cap_max = 15;

        // 3: simultaneous events, floor and ceiling saturation
        door_open = 1; step();
        pulses(1, 1, 1);
        cmp("t3 both no change", cap_des, 4);
        pulses(0, 1, 5);
        cmp("t3 floor", cap_des, 0);
        pulses(1, 0, 20);
        cmp("t3 ceiling", cap_des, 15);
        door_open = 0; step();
        wait_valid(20, n);
        finish_req();
        cmp("t3 cap_curr", cap_curr, 15);

        // 4: event restarts settle; door reopen returns to boarding
        door_open = 1; step();
        door_open = 0; step();
        repeat (4) step();
        pulses(0, 1, 1);
        wait_valid(20, n);
        cmp("t4 settle restart", n, 8);
        cmp("t4 cap_des", cap_des, 14);
        finish_req();
        door_open = 1; step();
        door_open = 0; step();
        repeat (3) step();
        door_open = 1;
        repeat (10) step();
        cmp("t4 reopen no valid", req_valid, 0);
        cmp("t4 reopen cap_des", cap_des, 14);
        door_open = 0; step();
        wait_valid(20, n);
        cmp("t4 reopen latency", n, 8);
        finish_req();

        // 5: reset while requesting
        door_open = 1; step();
        pulses(0, 1, 8);
        door_open = 0; step();
        wait_valid(20, n);
        cmp("t5 cap_des", cap_des, 6);
        @(negedge clk);
        rst_n = 0;
        #1;
        cmp("t5 rst cap_des", cap_des, 0);
        cmp("t5 rst req_valid", req_valid, 0);
        cmp("t5 rst cap_curr", cap_curr, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("t5 no door_close_ok", door_close_ok, 0);
        end
        @(negedge clk);
        rst_n = 1;
        pulses(1, 0, 3);
        cmp("t5 idle ignores enter", cap_des, 0);

        // 6: ack already high on REQ entry
        door_open = 1; step();
        pulses(1, 0, 2);
        door_open = 0; step();
        req_ack = 1;
        wait_valid(20, n);
        step();
        cmp("t6 single valid", req_valid, 0);
        cmp("t6 door_close_ok", door_close_ok, 1);
        cmp("t6 cap_curr", cap_curr, 2);
        req_ack = 0;
        step();
        cmp("t6 door_close_ok end", door_close_ok, 0);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) door_open = ~door_open;
            enter = ($urandom_range(3) == 0);
            exit = ($urandom_range(3) == 0);
            req_ack = ($urandom_range(2) == 0);
            if ($urandom_range(49) == 0) cap_max = W'($urandom_range(MAXV));
            rst_n = ($urandom_range(499) != 0);
            step();
        end
        rst_n = 1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
